// File: rtl/opti_pkg.sv
// Shared types and constants for the optical sample feeder.
// Holds the Q2.14 format constants, default frame length and feeder state enum.
package opti_pkg;

  localparam int DATA_W        = 16;
  localparam int FRAC_W        = 14;
  localparam int FRAME_LEN_DEF = 2048;
  localparam int CNT_W         = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_t;

  // Q1.15 -> Q2.14: add half an output LSB, then arithmetic shift right by one.
  function automatic logic [DATA_W-1:0] q15_to_q214(input logic [DATA_W-1:0] x);
    logic [DATA_W:0] ext;
    ext = {x[DATA_W-1], x} + {{DATA_W{1'b0}}, 1'b1};
    return ext[DATA_W:1];
  endfunction

endpackage

// File: rtl/opti_feeder_fifo.sv
// Synchronous sample FIFO for the feeder; pointers wrap modulo DEPTH (power of two).
// Push is ignored when full and pop is ignored when empty.
module opti_feeder_fifo
  import opti_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, not reset: contents are only visible through a valid pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opti_sample_feeder.sv
// Paces buffered upstream samples into the filter cascade, one strobe per SAMPLE_GAP cycles.
// Optional OPTI_FEEDER_Q15_EN: input is Q1.15 and is rounded to Q2.14 on pop.
module opti_sample_feeder
  import opti_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_GAP = 4,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
  localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  feeder_state_t                  state;
  feeder_state_t                  next_state;
  logic [GAP_W-1:0]               gap_cnt;
  logic [CNT_W-1:0]               sample_cnt;
  logic [DATA_W-1:0]              fifo_rdata;
  logic [DATA_W-1:0]              conv_data;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count;
  logic                           unused_count;
  logic                           push;
  logic                           gap_expired;
  logic                           can_issue;
  logic                           do_pop;
  logic                           starve;
  logic                           accept_start;

  assign s_ready      = !fifo_full;
  assign push         = s_valid && s_ready;
  assign unused_count = ^fifo_count;

  opti_feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_data),
    .pop   (do_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef OPTI_FEEDER_Q15_EN
  assign conv_data = q15_to_q214(fifo_rdata);
`else
  assign conv_data = fifo_rdata;
`endif

  // Issue slots only exist in RUN, after the gap, and before the frame is complete.
  assign gap_expired  = (gap_cnt == '0);
  assign can_issue    = (state == ST_RUN) && gap_expired && (sample_cnt < FRAME_END);
  assign do_pop       = can_issue && !fifo_empty;
  assign starve       = can_issue && fifo_empty;
  assign accept_start = (state == ST_IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sample_cnt == FRAME_END) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output strobes, pacing counter, frame counter and sticky underrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      gap_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      m_valid    <= do_pop;
      busy       <= (next_state != ST_IDLE);
      frame_done <= (next_state == ST_DONE);
      if (do_pop) begin
        m_data <= conv_data;
      end
      if (accept_start) begin
        sample_cnt <= '0;
        underrun   <= 1'b0;
        gap_cnt    <= '0;
      end else begin
        if (do_pop) begin
          gap_cnt    <= GAP_RELOAD;
          sample_cnt <= sample_cnt + CNT_ONE;
        end else if (!gap_expired) begin
          gap_cnt <= gap_cnt - GAP_ONE;
        end
        if (starve) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_opti_sample_feeder.sv
// Directed bench: instance a paces at gap 4 over a long frame, instance b runs
// 16-sample frames back-to-back from a continuous upstream stream.
module tb_opti_sample_feeder;

  logic        clk;
  logic        rst_a, start_a, sv_a, sr_a, mv_a, busy_a, fd_a, ur_a;
  logic [15:0] sd_a, md_a;
  logic        rst_b, start_b, sv_b, sr_b, mv_b, busy_b, fd_b, ur_b;
  logic [15:0] md_b, src_b;
  logic        src_clr;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_in  [4] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
`ifdef OPTI_FEEDER_Q15_EN
  logic [15:0] q_exp [4] = '{16'h4000, 16'hC000, 16'h0001, 16'h0000};
`else
  logic [15:0] q_exp [4] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
`endif

  opti_sample_feeder #(.FIFO_DEPTH(8), .SAMPLE_GAP(4), .FRAME_LEN(2048)) u_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .s_data(sd_a), .s_valid(sv_a),
    .s_ready(sr_a), .m_data(md_a), .m_valid(mv_a), .busy(busy_a),
    .frame_done(fd_a), .underrun(ur_a)
  );

  opti_sample_feeder #(.FIFO_DEPTH(8), .SAMPLE_GAP(1), .FRAME_LEN(16)) u_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .s_data(src_b), .s_valid(sv_b),
    .s_ready(sr_b), .m_data(md_b), .m_valid(mv_b), .busy(busy_b),
    .frame_done(fd_b), .underrun(ur_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream source for b: next value is offered only after a completed transfer.
  always @(posedge clk) begin
    if (src_clr) src_b <= 16'd1;
    else if (sv_b && sr_b) src_b <= src_b + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse_a(input string tag, input logic [15:0] exp);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (mv_a) begin
        seen = 1'b1;
        chk(tag, md_a, exp);
      end
    end
    chk({tag, "_seen"}, seen, 1'b1);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic prefill_a(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      sd_a = first + 16'(i * 256);
      sv_a = 1'b1;
      @(negedge clk);
    end
  endtask

  // Runs one b frame, checking every cycle; mid re-pulses start, abort stops early.
  task automatic run_frame_b(input string tag, input logic [15:0] base, input int mid, input int abort_at);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk({tag, "_busy0"}, busy_b, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      if (abort_at != 0 && n > abort_at) break;
      @(negedge clk);
      chk($sformatf("%s_mv%0d", tag, n), mv_b, (n <= 16));
      if (n <= 16) chk($sformatf("%s_md%0d", tag, n), md_b, base + 16'(n - 1));
      chk($sformatf("%s_fd%0d", tag, n), fd_b, (n == 17));
      chk($sformatf("%s_busy%0d", tag, n), busy_b, (n <= 17));
      chk($sformatf("%s_ur%0d", tag, n), ur_b, 1'b0);
      start_b = (n == mid);
    end
    start_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    sv_a = 1'b0; sv_b = 1'b0; sd_a = 16'h0000; src_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_md", md_a, 16'h0000);
    chk("rst_mv", mv_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_fd", fd_a, 1'b0);
    chk("rst_ur", ur_a, 1'b0);
    chk("rst_sr", sr_a, 1'b1);
    chk("rst_sr_b", sr_b, 1'b1);
    rst_a = 1'b1; rst_b = 1'b1; src_clr = 1'b0;

    // b: continuous stream, back-to-back frames
    sv_b = 1'b1;
    repeat (10) @(negedge clk);
    chk("b_full", sr_b, 1'b0);
    run_frame_b("f1", 16'd1, 0, 0);
    run_frame_b("f2", 16'd17, 5, 0);
    run_frame_b("f3", 16'd33, 0, 5);
    sv_b = 1'b0; rst_b = 1'b0; src_clr = 1'b1;
    @(negedge clk);
    chk("b_rst_md", md_b, 16'h0000);
    chk("b_rst_mv", mv_b, 1'b0);
    chk("b_rst_busy", busy_b, 1'b0);
    chk("b_rst_fd", fd_b, 1'b0);
    chk("b_rst_ur", ur_b, 1'b0);
    chk("b_rst_sr", sr_b, 1'b1);
    rst_b = 1'b1; src_clr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("b_no_done", fd_b, 1'b0);
    end
    sv_b = 1'b1;
    repeat (10) @(negedge clk);
    run_frame_b("f4", 16'd1, 0, 0);
    sv_b = 1'b0;

    // a: prefill eight, pulses four cycles apart, then starvation
    prefill_a(16'h0100, 8);
    sv_a = 1'b0;
    chk("a_full", sr_a, 1'b0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy", busy_a, 1'b1);
    for (int n = 1; n <= 36; n++) begin
      int k;
      @(negedge clk);
      k = (n >= 29) ? 7 : (n - 1) / 4;
      chk($sformatf("a_mv%0d", n), mv_a, ((n - 1) % 4 == 0) && (n <= 29));
      chk($sformatf("a_md%0d", n), md_a, 16'((k + 1) * 256));
      chk($sformatf("a_ur%0d", n), ur_a, (n >= 33));
    end

    // a: push into a full FIFO around a pop loses nothing
    reset_a();
    chk("a_rst_ur", ur_a, 1'b0);
    chk("a_rst_busy", busy_a, 1'b0);
    prefill_a(16'h0100, 8);
    sd_a = 16'h0900;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("pp_sr_full", sr_a, 1'b0);
    @(negedge clk);
    chk("pp_mv", mv_a, 1'b1);
    chk("pp_md", md_a, 16'h0100);
    chk("pp_sr_free", sr_a, 1'b1);
    @(negedge clk);
    chk("pp_sr_refull", sr_a, 1'b0);
    sv_a = 1'b0;
    for (int i = 2; i <= 9; i++) wait_pulse_a($sformatf("pp_md%0d", i), 16'(i * 256));

    // a: format conversion on pop
    reset_a();
    for (int i = 0; i < 4; i++) begin
      sd_a = q_in[i];
      sv_a = 1'b1;
      @(negedge clk);
    end
    sv_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) wait_pulse_a($sformatf("q_md%0d", i), q_exp[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
